// File: rtl/blink_pkg.sv
// Shared blink constants: rate codes (same encoding as the blinker's rate switch),
// decoder state encoding and the tolerance-window helpers.
package blink_pkg;

    typedef logic [1:0] rate_t;

    localparam rate_t RATE_100 = 2'b00;
    localparam rate_t RATE_50  = 2'b01;
    localparam rate_t RATE_10  = 2'b10;
    localparam rate_t RATE_1   = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    typedef struct packed {
        logic  hit;
        rate_t code;
    } cls_t;

    // Inclusive window centre +/- (centre >> shift), written to avoid underflow
    function automatic logic in_window(input logic [31:0] cnt, input logic [31:0] centre,
                                       input int unsigned shift);
        logic [31:0] tol;
        tol = centre >> shift;
        return ((cnt + tol) >= centre) && (cnt <= (centre + tol));
    endfunction

    function automatic logic win_disjoint(input logic [31:0] c_lo, input logic [31:0] c_hi,
                                          input int unsigned shift);
        return (c_lo + (c_lo >> shift)) < (c_hi - (c_hi >> shift));
    endfunction

endpackage

// File: rtl/blink_rate_decoder_if.sv
// Decoded-rate status bundle: the decoder drives it (master), consumers observe it (slave).
interface blink_rate_decoder_if;
    import blink_pkg::*;

    rate_t o_rate;
    logic  o_valid;
    logic  o_update;
    logic  o_lost;

    modport master (output o_rate, o_valid, o_update, o_lost);
    modport slave  (input  o_rate, o_valid, o_update, o_lost);
endinterface

// File: rtl/blink_edge_sync.sv
// Two-flop synchronizer plus registered both-edge detector; o_edge rises
// three clocks after a transition of the asynchronous input.
module blink_edge_sync (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_in,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_edge;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_meta <= i_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_edge <= r_sync ^ r_prev;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/blink_rate_decoder.sv
// Measures blink half-periods and locks onto one of four rates after two matching ones.
// Optional BLINK_RATE_DECODER_DBG_EN adds dbg_period / dbg_state observation ports.
module blink_rate_decoder
    import blink_pkg::*;
#(
    parameter int unsigned c100      = 125000,
    parameter int unsigned c50       = 250000,
    parameter int unsigned c10       = 1250000,
    parameter int unsigned c1        = 12500000,
    parameter int unsigned TOL_SHIFT = 3,
    parameter int unsigned CNT_W     = 24
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_led_sense,
    blink_rate_decoder_if.master  o_stat
`ifdef BLINK_RATE_DECODER_DBG_EN
    ,
    output logic [CNT_W-1:0]      dbg_period,
    output logic [1:0]            dbg_state
`endif
);

    localparam int unsigned TIMEOUT_LIM = c1 + (c1 >> TOL_SHIFT);
    localparam logic PARAMS_OK =
        win_disjoint(c100, c50, TOL_SHIFT) && win_disjoint(c50, c10, TOL_SHIFT) &&
        win_disjoint(c10, c1, TOL_SHIFT) && (CNT_W >= 1) && (CNT_W <= 32) &&
        (64'(TIMEOUT_LIM) < ((64'(1) << CNT_W) - 64'(1)));

    if (!PARAMS_OK) begin : g_param_check
        $error("blink_rate_decoder: overlapping tolerance windows or counter too narrow");
    end

    logic            w_edge;
    logic [CNT_W-1:0] r_count;
    logic [31:0]     w_count32;
    cls_t            w_cls;
    logic            w_timeout;

    logic [1:0] r_state,    w_state_nxt;
    rate_t      r_rate,     w_rate_nxt;
    logic       r_valid,    w_valid_nxt;
    logic       r_update,   w_update_nxt;
    logic       r_lost,     w_lost_nxt;
    rate_t      r_cand,     w_cand_nxt;
    logic       r_cand_vld, w_cand_vld_nxt;

    blink_edge_sync u_edge_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_in    (i_led_sense),
        .o_edge  (w_edge)
    );

    // Half-period counter: restarts at 1 on each edge, saturates instead of wrapping
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (w_edge) begin
            r_count <= CNT_W'(1);
        end else if (r_count != '1) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign w_count32 = 32'(r_count);

    // Window match of the count seen with the edge flag; the FSM registers consume it
    always_comb begin
        w_cls = '0;
        if (in_window(w_count32, c100, TOL_SHIFT)) begin
            w_cls.hit  = 1'b1;
            w_cls.code = RATE_100;
        end else if (in_window(w_count32, c50, TOL_SHIFT)) begin
            w_cls.hit  = 1'b1;
            w_cls.code = RATE_50;
        end else if (in_window(w_count32, c10, TOL_SHIFT)) begin
            w_cls.hit  = 1'b1;
            w_cls.code = RATE_10;
        end else if (in_window(w_count32, c1, TOL_SHIFT)) begin
            w_cls.hit  = 1'b1;
            w_cls.code = RATE_1;
        end
    end

    // An edge in the same cycle suppresses the timeout
    assign w_timeout = ((r_state == ST_MEASURE) || (r_state == ST_LOCKED)) && !w_edge &&
                       (w_count32 > TIMEOUT_LIM);

    always_comb begin
        w_state_nxt    = r_state;
        w_rate_nxt     = r_rate;
        w_valid_nxt    = r_valid;
        w_update_nxt   = 1'b0;
        w_lost_nxt     = r_lost && !w_edge;
        w_cand_nxt     = r_cand;
        w_cand_vld_nxt = r_cand_vld;

        if (!i_enable) begin
            w_state_nxt    = ST_IDLE;
            w_rate_nxt     = RATE_100;
            w_valid_nxt    = 1'b0;
            w_lost_nxt     = 1'b0;
            w_cand_nxt     = RATE_100;
            w_cand_vld_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    w_cand_vld_nxt = 1'b0;
                    if (w_edge) begin
                        w_state_nxt = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (w_edge) begin
                        if (!w_cls.hit) begin
                            w_cand_vld_nxt = 1'b0;
                        end else if (r_cand_vld && (w_cls.code == r_cand)) begin
                            w_state_nxt  = ST_LOCKED;
                            w_rate_nxt   = w_cls.code;
                            w_valid_nxt  = 1'b1;
                            w_update_nxt = 1'b1;
                        end else begin
                            w_cand_nxt     = w_cls.code;
                            w_cand_vld_nxt = 1'b1;
                        end
                    end else if (w_timeout) begin
                        w_state_nxt    = ST_ACQUIRE;
                        w_lost_nxt     = 1'b1;
                        w_valid_nxt    = 1'b0;
                        w_cand_vld_nxt = 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (w_edge) begin
                        if (!(w_cls.hit && (w_cls.code == r_rate))) begin
                            w_state_nxt    = ST_MEASURE;
                            w_valid_nxt    = 1'b0;
                            w_cand_nxt     = w_cls.code;
                            w_cand_vld_nxt = w_cls.hit;
                        end
                    end else if (w_timeout) begin
                        w_state_nxt    = ST_ACQUIRE;
                        w_lost_nxt     = 1'b1;
                        w_valid_nxt    = 1'b0;
                        w_cand_vld_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_rate     <= RATE_100;
            r_valid    <= 1'b0;
            r_update   <= 1'b0;
            r_lost     <= 1'b0;
            r_cand     <= RATE_100;
            r_cand_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rate     <= w_rate_nxt;
            r_valid    <= w_valid_nxt;
            r_update   <= w_update_nxt;
            r_lost     <= w_lost_nxt;
            r_cand     <= w_cand_nxt;
            r_cand_vld <= w_cand_vld_nxt;
        end
    end

    assign o_stat.o_rate   = r_rate;
    assign o_stat.o_valid  = r_valid;
    assign o_stat.o_update = r_update;
    assign o_stat.o_lost   = r_lost;

`ifdef BLINK_RATE_DECODER_DBG_EN
    logic [CNT_W-1:0] r_dbg_period;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_dbg_period <= '0;
        end else if (w_edge) begin
            r_dbg_period <= r_count;
        end
    end

    assign dbg_period = r_dbg_period;
    assign dbg_state  = r_state;
`endif

endmodule

// File: tb/tb_blink_rate_decoder.sv
// Directed bench for blink_rate_decoder: expected status words are queued with a due
// cycle when each input edge is driven, and checked by a negedge monitor.
module tb_blink_rate_decoder;
    import blink_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic led = 1'b0;
    int   cyc = 0;

    blink_rate_decoder_if bus ();

`ifdef BLINK_RATE_DECODER_DBG_EN
    logic [7:0] dbg_period;
    logic [1:0] dbg_state;
`endif

    blink_rate_decoder #(
        .c100(10), .c50(20), .c10(50), .c1(100), .TOL_SHIFT(3), .CNT_W(8)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_led_sense (led),
        .o_stat      (bus)
`ifdef BLINK_RATE_DECODER_DBG_EN
        ,
        .dbg_period  (dbg_period),
        .dbg_state   (dbg_state)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        string      tag;
        logic [4:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_upd = 0;
    int  t_ref = 0;
    bit  final_req  = 1'b0;
    bit  final_done = 1'b0;

    // Status word {valid, update, lost, rate}
    function automatic logic [4:0] st(input logic v, input logic u, input logic l,
                                      input logic [1:0] r);
        return {v, u, l, r};
    endfunction

    task automatic expect_at(input int dly, input string tag, input logic [4:0] e);
        sb.push_back('{due: t_ref + dly, tag: tag, exp: e});
    endtask

    task automatic go(input int p);
        repeat (p) @(negedge clk);
        led   = ~led;
        t_ref = cyc;
    endtask

    always @(negedge clk) begin
        logic [4:0] obs;
        obs = {bus.o_valid, bus.o_update, bus.o_lost, bus.o_rate};
        if (bus.o_update === 1'b1) n_upd++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                n_cmp++;
                assert (obs === sb[i].exp) else begin
                    n_bad++;
                    $error("FAIL %s: got v/u/l/rate=%b want %b", sb[i].tag, obs, sb[i].exp);
                end
                sb.delete(i);
            end
        end
        if (final_req && !final_done) begin
            final_done = 1'b1;
            n_cmp++;
            assert (sb.size() == 0) else begin
                n_bad++;
                $error("FAIL sb_drain: got %0d pending want 0", sb.size());
            end
            n_cmp++;
            assert (n_upd == 9) else begin
                n_bad++;
                $error("FAIL upd_count: got %0d pulses want 9", n_upd);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        t_ref = cyc;
        expect_at(1, "reset", st(0, 0, 0, RATE_100));
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        // 100 Hz: lock after the third edge
        go(5);   expect_at(4, "a_acq",  st(0, 0, 0, RATE_100));
        go(10);  expect_at(4, "a_cand", st(0, 0, 0, RATE_100));
        go(10);  expect_at(3, "a_pre",  st(0, 0, 0, RATE_100));
                 expect_at(4, "a_lock", st(1, 1, 0, RATE_100));
                 expect_at(5, "a_hold", st(1, 0, 0, RATE_100));
        go(10);  expect_at(4, "a_keep", st(1, 0, 0, RATE_100));

        // 1 Hz lock, then switch to 10 Hz
        go(100); expect_at(4, "b_drop",   st(0, 0, 0, RATE_100));
        go(100); expect_at(4, "b_lock1",  st(1, 1, 0, RATE_1));
                 expect_at(5, "b_hold1",  st(1, 0, 0, RATE_1));
        go(100); expect_at(4, "b_keep1",  st(1, 0, 0, RATE_1));
        go(50);  expect_at(4, "b_drop10", st(0, 0, 0, RATE_1));
        go(50);  expect_at(4, "b_lock10", st(1, 1, 0, RATE_10));
                 expect_at(5, "b_hold10", st(1, 0, 0, RATE_10));

        // Window bounds: 11 and 9 match 100 Hz, 13 does not
        go(11);  expect_at(4, "c_11", st(0, 0, 0, RATE_10));
        go(9);   expect_at(4, "c_9",  st(1, 1, 0, RATE_100));
        go(13);  expect_at(4, "c_13", st(0, 0, 0, RATE_100));

        // Relock, then starve the input into a timeout
        go(10);  expect_at(4,   "d_cand",     st(0, 0, 0, RATE_100));
        go(10);  expect_at(4,   "d_lock",     st(1, 1, 0, RATE_100));
                 expect_at(116, "d_pre_to",   st(1, 0, 0, RATE_100));
                 expect_at(117, "d_lost",     st(0, 0, 1, RATE_100));
        go(300); expect_at(3,   "d_lost_hold", st(0, 0, 1, RATE_100));
                 expect_at(4,   "d_lost_clr",  st(0, 0, 0, RATE_100));
        go(10);  expect_at(4,   "d_recand",   st(0, 0, 0, RATE_100));
        go(10);  expect_at(4,   "d_relock",   st(1, 1, 0, RATE_100));

        // Edge at count 113 beats the timeout and is a mismatch; 112 is still 1 Hz
        go(113); expect_at(4, "e_113",       st(0, 0, 0, RATE_100));
                 expect_at(5, "e_113_nolost", st(0, 0, 0, RATE_100));
        go(112); expect_at(4, "e_112",       st(0, 0, 0, RATE_100));
        go(100); expect_at(4, "e_lock",      st(1, 1, 0, RATE_1));
                 expect_at(5, "e_hold",      st(1, 0, 0, RATE_1));

        // Reset mid-lock with enable still high
        repeat (10) @(negedge clk);
        rst   = 1'b1;
        led   = 1'b0;
        t_ref = cyc;
        expect_at(1, "f_reset", st(0, 0, 0, RATE_100));
        @(negedge clk);
        rst = 1'b0;
        go(100); expect_at(4, "f_acq",  st(0, 0, 0, RATE_100));
        go(100); expect_at(4, "f_cand", st(0, 0, 0, RATE_100));
        go(100); expect_at(4, "f_lock", st(1, 1, 0, RATE_1));

        // Disable mid-lock; edges are ignored until re-enabled
        repeat (10) @(negedge clk);
        en    = 1'b0;
        t_ref = cyc;
        expect_at(1, "g_dis", st(0, 0, 0, RATE_100));
        go(100); expect_at(4, "g_dis_edge", st(0, 0, 0, RATE_100));
        repeat (10) @(negedge clk);
        en = 1'b1;
        go(100); expect_at(4, "g_acq",  st(0, 0, 0, RATE_100));
        go(100); expect_at(4, "g_cand", st(0, 0, 0, RATE_100));
        go(100); expect_at(4, "g_lock", st(1, 1, 0, RATE_1));

        repeat (10) @(negedge clk);
        final_req = 1'b1;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/blink_rate_decoder.md
BLINK_RATE_DECODER -- requirements
Module: blink_rate_decoder

Interface
REQ-001 SHALL have parameter c100, default 125000: expected half-period, in clocks, of the 100 Hz rate.
REQ-002 SHALL have parameter c50, default 250000: expected half-period of the 50 Hz rate.
REQ-003 SHALL have parameter c10, default 1250000: expected half-period of the 10 Hz rate.
REQ-004 SHALL have parameter c1, default 12500000: expected half-period of the 1 Hz rate.
REQ-005 SHALL have parameter TOL_SHIFT, default 3: tolerance is ±(cX >> TOL_SHIFT).
REQ-006 SHALL have parameter CNT_W, default 24: width of the period counter.
REQ-007 i_clock  in  1  sole clock; all logic on its rising edge.
REQ-008 i_reset  in  1  reset, synchronous and active-high.
REQ-009 i_enable  in  1  decoder run; 0 forces IDLE.
REQ-010 i_led_sense  in  1  asynchronous blink input, e.g. the o_led_drive of a blinker.
REQ-011 o_rate  out  2  decoded rate code: 00=100 Hz, 01=50 Hz, 10=10 Hz, 11=1 Hz; meaningful only while o_valid=1.
REQ-012 o_valid  out  1  high while LOCKED.
REQ-013 o_update  out  1  one-cycle strobe on each entry to LOCKED.
REQ-014 o_lost  out  1  high from a timeout until the next input edge.

Function
REQ-015 i_led_sense SHALL pass through a 2-flop synchronizer followed by a registered edge detector that detects both edges; the edge flag is asserted 3 cycles after the input transition.
REQ-016 The period counter SHALL clear to 1 on an edge, otherwise increment, and saturate at all-ones.
REQ-017 On an edge, the counter value SHALL be classified as code k when |count − cK| <= cK >> TOL_SHIFT, with bounds inclusive; if no window matches, the value is a mismatch.
REQ-018 The classification SHALL be registered one cycle after the edge flag.
REQ-019 The state machine SHALL have states IDLE, ACQUIRE, MEASURE and LOCKED.
REQ-020 IDLE→ACQUIRE SHALL occur when i_enable=1, and any state SHALL go to IDLE on the next cycle when i_enable=0.
REQ-021 ACQUIRE→MEASURE SHALL occur on the first edge; that first count is discarded.
REQ-022 MEASURE→LOCKED SHALL occur when two consecutive classifications yield the same code; o_rate SHALL be loaded and o_update SHALL pulse in the same cycle that o_valid rises.
REQ-023 In LOCKED, a classification with the same code SHALL keep the lock with no o_update pulse.
REQ-024 In LOCKED, a mismatch or a different code SHALL cause →MEASURE with o_valid=0; a different code SHALL be held as the first candidate.
REQ-025 A timeout, defined as count > c1 + (c1 >> TOL_SHIFT) in MEASURE or LOCKED, SHALL cause →ACQUIRE with o_lost=1 and o_valid=0.
REQ-026 When an edge and a timeout occur in the same cycle, the edge SHALL win and no timeout is taken.
REQ-027 o_rate SHALL hold its last value while o_valid=0.
REQ-028 Tolerance windows SHALL NOT overlap; this is a parameter legality rule, and the implementation reports violations via an elaboration-time check.

Reset
REQ-029 On i_reset=1 at a clock edge, the state SHALL go to IDLE and the counter, synchronizer, candidate, o_rate, o_valid, o_update and o_lost SHALL clear to 0.
REQ-030 i_reset SHALL have priority over i_enable.
REQ-031 After i_reset deasserts, the block SHALL require a full reacquisition of two matching half-periods before o_valid is asserted.

Configuration
REQ-032 With BLINK_RATE_DECODER_DBG_EN defined, the module SHALL add ports dbg_period (out, CNT_W: last measured count) and dbg_state (out, 2: state encoding); both reset to 0.
REQ-033 Without BLINK_RATE_DECODER_DBG_EN, these ports and their registers SHALL be absent and functional behaviour SHALL be identical.

Structure
REQ-034 Shared package blink_pkg SHALL hold the rate-code constants RATE_100/50/10/1 (shared with the blinker's switch encoding) and the decoder state encoding.
REQ-035 Sub-module blink_edge_sync SHALL contain the 2-flop synchronizer and the edge detector; classification and the FSM stay in the top module.

Verification (c100=10, c50=20, c10=50, c1=100, TOL_SHIFT=3)
REQ-036 Toggle the input every 10 clocks → o_valid=1 and o_rate=00 after the 3rd edge plus 4 clocks, with one o_update pulse.
REQ-037 Toggle every 100 clocks → lock with o_rate=11; then switch to toggling every 50 clocks → o_valid drops, relock with o_rate=10, and a second o_update pulse.
REQ-038 Half-periods of 11, then 9, then 13 clocks against c100 → 11 and 9 both classify 00 and lock; 13 is a mismatch, causing o_valid=0 and →MEASURE.
REQ-039 Hold the input static after lock → o_lost=1 and o_valid=0 once count reaches 113; the next edge clears o_lost.
REQ-040 Pulse i_reset and separately deassert i_enable mid-LOCKED → all outputs 0 on the next cycle, with reacquisition required afterwards.
REQ-041 An edge arriving at exactly count=113 → no timeout, and the value is classified as a mismatch.
